stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before a button level is accepted (10 ms at 100 MHz).
REQ-002 SHALL have port: clk_100MHz  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: btn_start  input  1  raw start/stop pushbutton, asynchronous, bouncing.
REQ-005 SHALL have port: btn_clear  input  1  raw clear pushbutton, asynchronous, bouncing.
REQ-006 SHALL have port: btn_lap  input  1  raw lap pushbutton, asynchronous, bouncing.
REQ-007 SHALL have port: tick_in  input  1  one-cycle 10 Hz count strobe from the tick generator.
REQ-008 SHALL have port: tick_out  output  1  gated count strobe to the BCD digit counter.
REQ-009 SHALL have port: cnt_clr  output  1  one-cycle pulse clearing the BCD digit counter.
REQ-010 SHALL have port: hold  output  1  level; display freezes its latched digits while high.
REQ-011 SHALL have port: state  output  2  current FSM state encoding.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a debouncer; debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle count restarts on a bounce.
REQ-013 A press event SHALL be a one-cycle pulse on the rising edge of the debounced level; releases generate no event.
REQ-014 FSM states SHALL be IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-015 Transitions: IDLE-start->RUN; RUN-start->PAUSE; RUN-lap->LAP; LAP-lap->RUN; LAP-start->PAUSE; PAUSE-start->RUN; PAUSE-clear->IDLE; IDLE-clear->IDLE; all other events ignored (clear ignored in RUN and LAP).
REQ-016 Simultaneous events in one cycle SHALL resolve by priority clear > start > lap; only the highest acted on, others discarded.
REQ-017 State SHALL update on the cycle after the press pulse.
REQ-018 cnt_clr SHALL pulse exactly one cycle, registered, coincident with the state register taking the clear transition.
REQ-019 tick_out SHALL equal tick_in delayed one cycle, gated by state in {RUN, LAP} at the cycle tick_in was sampled.
REQ-020 hold SHALL be registered high exactly while state==LAP.
REQ-021 No tick_out SHALL occur in IDLE or PAUSE, including a tick_in coincident with the press leaving RUN/LAP (gate uses pre-transition state).

Reset
REQ-022 Reset assertion SHALL immediately force state=IDLE, tick_out=0, cnt_clr=0, hold=0, debounced levels=0, debounce counters=0, synchronizers=0.
REQ-023 A button held through reset release SHALL produce one press event after DEBOUNCE_CYCLES, not at release.
REQ-024 Reset mid-debounce or mid-LAP SHALL discard all pending events; no cnt_clr pulse on reset.

Configuration
REQ-025 Macro STOPWATCH_LAP_EN defined: lap button, LAP state and hold behave as above.
REQ-026 Macro undefined: btn_lap ignored (no debouncer instantiated), LAP unreachable, hold tied 0, state never 3.

Structure
REQ-027 Shared package stopwatch_pkg SHALL hold the state encoding constants and the default DEBOUNCE_CYCLES.
REQ-028 Synchronizer plus debouncer plus edge detect SHALL be sub-module btn_debounce (one instance per button), output: debounced level and press pulse.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-029 btn_start bounces 1-0-1 for 3 cycles then stable high 10 cycles -> exactly one press, state 0->1 at cycle sync(2)+4+2 after final edge.
REQ-030 RUN, tick_in pulses every 10 cycles for 50 cycles -> 5 tick_out pulses each 1 cycle late; after start press (PAUSE) -> zero tick_out.
REQ-031 PAUSE, clear press -> state=0 and single cnt_clr pulse same cycle; clear press in RUN -> no cnt_clr, state stays 1.
REQ-032 RUN, start and clear debounced-edge same cycle -> start ignored? no: clear ignored in RUN, start wins -> state=2; in PAUSE same pair -> clear wins, state=0, cnt_clr=1.
REQ-033 With STOPWATCH_LAP_EN: RUN, lap press -> state=3, hold=1, tick_out continues; lap again -> state=1, hold=0; without macro, lap press -> state stays 1, hold=0.
REQ-034 Reset asserted in LAP mid-cycle -> outputs zero asynchronously; btn_start held across release -> one press after 4+2 cycles, state=1.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: the FSM state encoding,
// the default debounce length and a helper that says which states let the
// count strobe through to the digit counter.
// Optional feature macro used by this slice: STOPWATCH_LAP_EN.
package stopwatch_pkg;

    // Encoding is visible on the state output port, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    // 10 ms of stable level at the 100 MHz system clock.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // The digit counter advances only while the stopwatch is timing.
    // LAP keeps counting underneath a frozen display.
    function automatic logic isCounting(input state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce: conditions one raw pushbutton for the stopwatch controller.
// A two-flop synchronizer removes metastability, a counter accepts a new
// level only after it has been seen continuously for DEBOUNCE_CYCLES cycles,
// and a registered edge detector turns each accepted press into a single
// one-cycle pulse. Releases produce no pulse.
// Optional feature macro of the enclosing design: STOPWATCH_LAP_EN (unused here).
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_count;
    logic          r_level;
    logic          r_levelDly;
    logic          r_press;
    logic          w_mismatch;

    assign w_mismatch = (r_sync[1] != r_level);

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    // Count consecutive cycles the synchronized input disagrees with the
    // accepted level; any agreeing cycle (a bounce) restarts the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_level <= 1'b0;
        end else if (!w_mismatch) begin
            r_count <= '0;
        end else if (r_count == LAST_COUNT) begin
            r_count <= '0;
            r_level <= r_sync[1];
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    // Registered rising-edge detect on the accepted level gives a clean
    // one-cycle press pulse that downstream logic can sample directly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_levelDly <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_levelDly <= r_level;
            r_press    <= r_level & ~r_levelDly;
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control FSM for a stopwatch built from a 10 Hz tick
// generator, a BCD digit counter and a latching display. It debounces the
// start/stop, clear and lap buttons, steps IDLE/RUN/PAUSE/LAP, gates the
// count strobe, pulses the counter clear and freezes the display during LAP.
// Optional feature macro: STOPWATCH_LAP_EN enables the lap button, the LAP
// state and the hold output; without it btn_lap is ignored and hold is 0.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic       tick_in,
    output logic       tick_out,
    output logic       cnt_clr,
    output logic       hold,
    output logic [1:0] state
);

    state_t r_state;
    state_t w_stateNext;
    logic   w_clearTaken;
    logic   w_startPress;
    logic   w_clearPress;
    logic   w_lapPress;
    logic   w_unusedStartLevel;
    logic   w_unusedClearLevel;
    logic   r_tickOut;
    logic   r_cntClr;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_startBtn (
        .i_clk   (clk_100MHz),
        .i_rst   (reset),
        .i_btn   (btn_start),
        .o_level (w_unusedStartLevel),
        .o_press (w_startPress)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clearBtn (
        .i_clk   (clk_100MHz),
        .i_rst   (reset),
        .i_btn   (btn_clear),
        .o_level (w_unusedClearLevel),
        .o_press (w_clearPress)
    );

`ifdef STOPWATCH_LAP_EN
    logic w_unusedLapLevel;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lapBtn (
        .i_clk   (clk_100MHz),
        .i_rst   (reset),
        .i_btn   (btn_lap),
        .o_level (w_unusedLapLevel),
        .o_press (w_lapPress)
    );
`else
    logic w_unusedLapBtn;

    assign w_unusedLapBtn = btn_lap;
    assign w_lapPress     = 1'b0;
`endif

    // State register; the press pulse is sampled here, so the state moves
    // on the cycle after the pulse is seen.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode. Within each state the if/else order gives clear
    // priority over start over lap, but only among events that state
    // accepts, so an ignored clear in RUN/LAP never masks a start.
    always_comb begin
        w_stateNext  = r_state;
        w_clearTaken = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_clearPress) begin
                    w_clearTaken = 1'b1;
                end else if (w_startPress) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_startPress) begin
                    w_stateNext = ST_PAUSE;
                end else if (w_lapPress) begin
                    w_stateNext = ST_LAP;
                end
            end
            ST_PAUSE: begin
                if (w_clearPress) begin
                    w_stateNext  = ST_IDLE;
                    w_clearTaken = 1'b1;
                end else if (w_startPress) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_LAP: begin
                if (w_startPress) begin
                    w_stateNext = ST_PAUSE;
                end else if (w_lapPress) begin
                    w_stateNext = ST_RUN;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Count strobe is delayed one cycle and gated by the state in force
    // when tick_in was sampled, i.e. before any transition on that edge.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_tickOut <= 1'b0;
        end else begin
            r_tickOut <= tick_in & isCounting(r_state);
        end
    end

    // Counter clear is registered alongside the state so it lands on the
    // same edge the state register takes the clear transition.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_cntClr <= 1'b0;
        end else begin
            r_cntClr <= w_clearTaken;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic r_hold;

    // Hold follows the next state so it is high exactly while state is LAP.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_hold <= 1'b0;
        end else begin
            r_hold <= (w_stateNext == ST_LAP);
        end
    end

    assign hold = r_hold;
`else
    assign hold = 1'b0;
`endif

    assign tick_out = r_tickOut;
    assign cnt_clr  = r_cntClr;
    assign state    = r_state;

endmodule
